busca_instrucao: RTL and testbench

- Instruction-fetch unit on the consumer side of the program-counter register: it takes the current PC, issues word reads to instruction memory over a valid/ready handshake, and buffers the returned instructions with their PCs.
- It produces pc_prox back to the PC register: advance by 4 on each accepted request, hold otherwise, or load a redirect target.
- Supports branch redirect: flushes the buffer and discards any in-flight responses.

---
 rtl/busca_instrucao_pkg.sv | 18 +
 rtl/fila_sincrona.sv | 55 +++++
 rtl/busca_instrucao.sv | 140 ++++++++++++++
 tb/tb_busca_instrucao.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/busca_instrucao_pkg.sv
// Shared constants and entry layout for the instruction-fetch unit.
package busca_instrucao_pkg;

    localparam int LARG_END_PADRAO = 32;
    localparam int LARG_INSTR      = 32;
    localparam int INCREMENTO_PC   = 4;

    // Buffer entry at the default address width; the top rebuilds it for other widths.
    typedef struct packed {
        logic [LARG_INSTR-1:0]      instr;
        logic [LARG_END_PADRAO-1:0] pc;
    } entrada_buffer_t;

    function automatic logic pc_alinhado(input logic [1:0] lsb);
        return lsb == 2'b00;
    endfunction

endpackage

// File: rtl/fila_sincrona.sv
// Synchronous FIFO with flush; push while full is accepted only alongside a pop.
module fila_sincrona #(
    parameter int LARGURA      = 32,
    parameter int PROFUNDIDADE = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          limpa,
    input  logic                          push,
    input  logic [LARGURA-1:0]            dado_in,
    input  logic                          pop,
    output logic [LARGURA-1:0]            dado_out,
    output logic                          cheia,
    output logic                          vazia,
    output logic [$clog2(PROFUNDIDADE):0] contagem
);

    localparam int AW = $clog2(PROFUNDIDADE);

    logic [LARGURA-1:0] mem [PROFUNDIDADE];
    logic [AW-1:0]      ptr_esc;
    logic [AW-1:0]      ptr_lei;
    logic [AW:0]        cont;
    logic               faz_push;
    logic               faz_pop;

    assign vazia    = (cont == '0);
    assign cheia    = (cont == (AW+1)'(PROFUNDIDADE));
    assign contagem = cont;
    assign dado_out = mem[ptr_lei];
    assign faz_pop  = pop & !vazia;
    assign faz_push = push & (!cheia | faz_pop);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_esc <= '0;
            ptr_lei <= '0;
            cont    <= '0;
        end else if (limpa) begin
            ptr_esc <= '0;
            ptr_lei <= '0;
            cont    <= '0;
        end else begin
            if (faz_push) ptr_esc <= ptr_esc + AW'(1);
            if (faz_pop)  ptr_lei <= ptr_lei + AW'(1);
            cont <= cont + (AW+1)'(faz_push) - (AW+1)'(faz_pop);
        end
    end

    // Storage needs no reset: the count alone decides what is valid.
    always_ff @(posedge clock) begin
        if (faz_push && !limpa) mem[ptr_esc] <= dado_in;
    end

endmodule

// File: rtl/busca_instrucao.sv
// Instruction fetch: issues word reads at pc_atual, buffers {instr, pc}, handles redirects.
module busca_instrucao
    import busca_instrucao_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int LARG_END = LARG_END_PADRAO
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [LARG_END-1:0]   pc_atual,
    output logic [LARG_END-1:0]   pc_prox,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [LARG_END-1:0]   mem_req_end,
    input  logic                  mem_resp_valid,
    input  logic [LARG_INSTR-1:0] mem_resp_dado,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [LARG_INSTR-1:0] instr,
    output logic [LARG_END-1:0]   instr_pc,
    input  logic                  redirect_valid,
    input  logic [LARG_END-1:0]   redirect_alvo,
    output logic                  erro_alinhamento
);

    localparam int CW = $clog2(DEPTH);
    // Repeated redirects can stack discards beyond DEPTH, so leave headroom.
    localparam int DW = CW + 8;

    typedef struct packed {
        logic [LARG_INSTR-1:0] instr;
        logic [LARG_END-1:0]   pc;
    } entrada_t;

    logic [CW:0]         pend;
    logic [CW:0]         cont_buffer;
    logic [CW+1:0]       ocupacao;
    logic [DW-1:0]       descarte;
    logic [DW-1:0]       descarte_d;
    logic                erro_d;
    logic                dispara;
    logic                aceita_resp;
    logic                resp_descartada;
    logic                pop_instr;
    logic                end_vazia;
    logic                end_cheia;
    logic                buf_vazio;
    logic                buf_cheio;
    logic [LARG_END-1:0] pc_pendente;
    entrada_t            entrada_in;
    entrada_t            entrada_out;

    assign ocupacao = {1'b0, pend} + {1'b0, cont_buffer};

    assign mem_req_valid = !reset && !redirect_valid && !erro_alinhamento &&
                           pc_alinhado(pc_atual[1:0]) && !end_cheia && !buf_cheio &&
                           (ocupacao < (CW+2)'(DEPTH));
    assign mem_req_end   = pc_atual;
    assign dispara       = mem_req_valid && mem_req_ready;

    assign resp_descartada = mem_resp_valid &&
                             ((descarte != '0) || (redirect_valid && !end_vazia));
    assign aceita_resp     = mem_resp_valid && !redirect_valid &&
                             (descarte == '0) && !end_vazia;

    assign instr_valid = !buf_vazio;
    assign instr       = entrada_out.instr;
    assign instr_pc    = entrada_out.pc;
    assign pop_instr   = instr_valid && instr_ready;

    assign entrada_in.instr = mem_resp_dado;
    assign entrada_in.pc    = pc_pendente;

    always_comb begin
        pc_prox = pc_atual;
        if (redirect_valid)
            pc_prox = redirect_alvo;
        else if (dispara)
            pc_prox = pc_atual + LARG_END'(INCREMENTO_PC);
    end

    // Outstanding reads move into the discard count on redirect.
    always_comb begin
        descarte_d = descarte;
        erro_d     = erro_alinhamento;
        if (redirect_valid) begin
            descarte_d = descarte + DW'(pend) - DW'(resp_descartada);
            erro_d     = 1'b0;
        end else begin
            if (resp_descartada)
                descarte_d = descarte - DW'(1);
            if (!pc_alinhado(pc_atual[1:0]))
                erro_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            descarte         <= '0;
            erro_alinhamento <= 1'b0;
        end else begin
            descarte         <= descarte_d;
            erro_alinhamento <= erro_d;
        end
    end

    // The address FIFO occupancy is the outstanding-request count.
    fila_sincrona #(
        .LARGURA      (LARG_END),
        .PROFUNDIDADE (DEPTH)
    ) u_fila_end (
        .clock    (clock),
        .reset    (reset),
        .limpa    (redirect_valid),
        .push     (dispara),
        .dado_in  (pc_atual),
        .pop      (aceita_resp),
        .dado_out (pc_pendente),
        .cheia    (end_cheia),
        .vazia    (end_vazia),
        .contagem (pend)
    );

    fila_sincrona #(
        .LARGURA      ($bits(entrada_t)),
        .PROFUNDIDADE (DEPTH)
    ) u_fila_instr (
        .clock    (clock),
        .reset    (reset),
        .limpa    (redirect_valid),
        .push     (aceita_resp),
        .dado_in  (entrada_in),
        .pop      (pop_instr),
        .dado_out (entrada_out),
        .cheia    (buf_cheio),
        .vazia    (buf_vazio),
        .contagem (cont_buffer)
    );

endmodule

// File: tb/tb_busca_instrucao.sv
// Directed bench: the bench plays PC register and memory, stepping each cycle by hand.
module tb_busca_instrucao;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] pc_atual;
    logic [31:0] pc_prox;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_end;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_dado;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_alvo;
    logic        erro_alinhamento;

    int vetores = 0;
    int erros   = 0;

    busca_instrucao #(.DEPTH(4), .LARG_END(32)) dut (
        .clock            (clock),
        .reset            (reset),
        .pc_atual         (pc_atual),
        .pc_prox          (pc_prox),
        .mem_req_valid    (mem_req_valid),
        .mem_req_ready    (mem_req_ready),
        .mem_req_end      (mem_req_end),
        .mem_resp_valid   (mem_resp_valid),
        .mem_resp_dado    (mem_resp_dado),
        .instr_valid      (instr_valid),
        .instr_ready      (instr_ready),
        .instr            (instr),
        .instr_pc         (instr_pc),
        .redirect_valid   (redirect_valid),
        .redirect_alvo    (redirect_alvo),
        .erro_alinhamento (erro_alinhamento)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vetores++;
        assert (obs === exp) else begin
            erros++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; pc_atual = 32'h0; mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0; mem_resp_dado = 32'h0; instr_ready = 1'b0;
        redirect_valid = 1'b0; redirect_alvo = 32'h0;
        #2;
        chk("rst_req_valid", mem_req_valid, 0);
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_erro", erro_alinhamento, 0);
        chk("rst_pc_prox", pc_prox, 32'h0);

        // Basic fetch with one-cycle memory latency
        tick(); reset = 1'b0; mem_req_ready = 1'b1; #1;
        chk("t1_req_valid", mem_req_valid, 1);
        chk("t1_req_end", mem_req_end, 32'h0);
        chk("t1_pc_prox", pc_prox, 32'h4);
        tick(); pc_atual = 32'h4; mem_req_ready = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_dado = 32'h00A00093; #1;
        chk("t1_instr_valid_early", instr_valid, 0);
        chk("t1_pc_hold", pc_prox, 32'h4);
        tick(); mem_resp_valid = 1'b0; #1;
        chk("t1_instr_valid", instr_valid, 1);
        chk("t1_instr", instr, 32'h00A00093);
        chk("t1_instr_pc", instr_pc, 32'h0);
        instr_ready = 1'b1;
        tick(); instr_ready = 1'b0; #1;
        chk("t1_drained", instr_valid, 0);

        // Backpressure: credit limit of four
        redirect_valid = 1'b1; redirect_alvo = 32'h0; mem_req_ready = 1'b1; #1;
        chk("t2_redir_no_req", mem_req_valid, 0);
        chk("t2_redir_pc", pc_prox, 32'h0);
        tick(); redirect_valid = 1'b0; pc_atual = 32'h0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t2_req_valid", mem_req_valid, 1);
            chk("t2_req_end", mem_req_end, 32'(4 * i));
            chk("t2_pc_prox", pc_prox, 32'(4 * i + 4));
            tick(); pc_atual = 32'(4 * i + 4);
        end
        #1;
        chk("t2_full_stop", mem_req_valid, 0);
        chk("t2_full_pc_hold", pc_prox, 32'h10);
        for (int i = 0; i < 4; i++) begin
            mem_resp_valid = 1'b1; mem_resp_dado = 32'(32'h1000 + i); #1;
            chk("t2_resp_no_req", mem_req_valid, 0);
            tick();
        end
        mem_resp_valid = 1'b0; instr_ready = 1'b1; #1;
        chk("t2_head_instr", instr, 32'h1000);
        chk("t2_head_pc", instr_pc, 32'h0);
        chk("t2_pop_not_credited", mem_req_valid, 0);
        tick(); instr_ready = 1'b0; #1;
        chk("t2_credit_req", mem_req_valid, 1);
        chk("t2_credit_end", mem_req_end, 32'h10);
        chk("t2_credit_pc_prox", pc_prox, 32'h14);
        chk("t2_next_instr", instr, 32'h1001);
        tick(); pc_atual = 32'h14; #1;
        chk("t2_full_again", mem_req_valid, 0);

        // Redirect with two outstanding requests
        mem_req_ready = 1'b0; instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t3_drain_pc", instr_pc, 32'(4 * i + 4));
            tick();
        end
        instr_ready = 1'b0; mem_req_ready = 1'b1; #1;
        chk("t3_drained", instr_valid, 0);
        chk("t3_req_end", mem_req_end, 32'h14);
        tick(); pc_atual = 32'h18;
        redirect_valid = 1'b1; redirect_alvo = 32'h100; #1;
        chk("t3_redir_no_req", mem_req_valid, 0);
        chk("t3_redir_pc", pc_prox, 32'h100);
        tick(); redirect_valid = 1'b0; mem_req_ready = 1'b0; pc_atual = 32'h100; #1;
        chk("t3_buf_empty", instr_valid, 0);
        chk("t3_req_resume", mem_req_valid, 1);
        chk("t3_req_end_tgt", mem_req_end, 32'h100);
        mem_req_ready = 1'b1;
        tick(); mem_req_ready = 1'b0; pc_atual = 32'h104;
        mem_resp_valid = 1'b1; mem_resp_dado = 32'hDEAD0001;
        tick(); mem_resp_dado = 32'hDEAD0002; #1;
        chk("t3_drop1", instr_valid, 0);
        tick(); mem_resp_dado = 32'h00000113; #1;
        chk("t3_drop2", instr_valid, 0);
        tick(); mem_resp_valid = 1'b0; #1;
        chk("t3_deliver_valid", instr_valid, 1);
        chk("t3_deliver_instr", instr, 32'h00000113);
        chk("t3_deliver_pc", instr_pc, 32'h100);
        instr_ready = 1'b1;
        tick(); instr_ready = 1'b0;

        // Redirect coinciding with a response
        mem_req_ready = 1'b1;
        tick(); mem_req_ready = 1'b1; pc_atual = 32'h108;
        redirect_valid = 1'b1; redirect_alvo = 32'h200;
        mem_resp_valid = 1'b1; mem_resp_dado = 32'h00000BAD; #1;
        chk("t4_no_req", mem_req_valid, 0);
        chk("t4_pc_prox", pc_prox, 32'h200);
        tick(); redirect_valid = 1'b0; mem_resp_valid = 1'b0; pc_atual = 32'h200; #1;
        chk("t4_buf_empty", instr_valid, 0);
        chk("t4_req_end", mem_req_end, 32'h200);
        tick(); mem_req_ready = 1'b0; pc_atual = 32'h204;
        mem_resp_valid = 1'b1; mem_resp_dado = 32'h00000222;
        tick(); mem_resp_valid = 1'b0; #1;
        chk("t4_no_extra_discard", instr_valid, 1);
        chk("t4_instr", instr, 32'h00000222);
        chk("t4_instr_pc", instr_pc, 32'h200);
        instr_ready = 1'b1;
        tick(); instr_ready = 1'b0;

        // Misaligned PC
        pc_atual = 32'h6; mem_req_ready = 1'b1; #1;
        chk("t5_no_req", mem_req_valid, 0);
        chk("t5_pc_hold", pc_prox, 32'h6);
        chk("t5_erro_not_yet", erro_alinhamento, 0);
        tick(); pc_atual = 32'h8; #1;
        chk("t5_erro_set", erro_alinhamento, 1);
        chk("t5_stopped", mem_req_valid, 0);
        tick(); #1;
        chk("t5_erro_sticky", erro_alinhamento, 1);
        redirect_valid = 1'b1; redirect_alvo = 32'h8; #1;
        chk("t5_redir_pc", pc_prox, 32'h8);
        tick(); redirect_valid = 1'b0; #1;
        chk("t5_erro_clear", erro_alinhamento, 0);
        chk("t5_resume", mem_req_valid, 1);
        chk("t5_resume_end", mem_req_end, 32'h8);
        tick(); pc_atual = 32'hC;

        // Reset with three outstanding and one buffered
        tick(); pc_atual = 32'h10;
        tick(); pc_atual = 32'h14;
        tick(); pc_atual = 32'h18; mem_req_ready = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_dado = 32'h00000333;
        tick(); mem_resp_valid = 1'b0; #1;
        chk("t6_buffered_pc", instr_pc, 32'h8);
        chk("t6_buffered_instr", instr, 32'h00000333);
        reset = 1'b1; #1;
        chk("t6_rst_instr_valid", instr_valid, 0);
        chk("t6_rst_req_valid", mem_req_valid, 0);
        chk("t6_rst_pc_prox", pc_prox, 32'h18);
        tick(); reset = 1'b0; pc_atual = 32'h40;
        mem_resp_valid = 1'b1; mem_resp_dado = 32'h00000444; #1;
        chk("t6_req_after_rst", mem_req_valid, 1);
        tick(); #1;
        chk("t6_stale_ignored1", instr_valid, 0);
        tick(); mem_resp_valid = 1'b0; #1;
        chk("t6_stale_ignored2", instr_valid, 0);
        mem_req_ready = 1'b1; #1;
        chk("t6_restart_end", mem_req_end, 32'h40);
        chk("t6_restart_pc_prox", pc_prox, 32'h44);
        tick(); mem_req_ready = 1'b0; pc_atual = 32'h44;
        mem_resp_valid = 1'b1; mem_resp_dado = 32'h00000555;
        tick(); mem_resp_valid = 1'b0; #1;
        chk("t6_restart_instr", instr, 32'h00000555);
        chk("t6_restart_pc", instr_pc, 32'h40);

        // PC increment wraps at the top of the address space
        pc_atual = 32'hFFFFFFFC; mem_req_ready = 1'b1; #1;
        chk("wrap_pc_prox", pc_prox, 32'h0);
        mem_req_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vetores, erros);
        $finish;
    end

endmodule
